// File: rtl/airi5c_pipe_regs_pkg.sv
// Shared constants for the pipeline register slice: parameter defaults,
// legal depth range and the per-cycle stage operation encoding.
package airi5c_pipe_regs_pkg;

  localparam int PIPE_DATA_W_DEF = 32;
  localparam int PIPE_FLAG_W_DEF = 2;
  localparam int PIPE_DEPTH_DEF  = 1;
  localparam int PIPE_CNT_W_DEF  = 8;
  localparam int PIPE_DEPTH_MIN  = 1;
  localparam int PIPE_DEPTH_MAX  = 4;

  typedef enum logic [1:0] {
    PIPE_ADVANCE = 2'd0,
    PIPE_STALL   = 2'd1,
    PIPE_FLUSH   = 2'd2
  } pipe_op_e;

  // Flush outranks stall; reset is handled directly by the flops.
  function automatic pipe_op_e pipe_op(input logic stall, input logic flush);
    if (flush)      return PIPE_FLUSH;
    else if (stall) return PIPE_STALL;
    else            return PIPE_ADVANCE;
  endfunction

endpackage

// File: rtl/airi5c_pipe_regs_if.sv
// Control and payload bundle of the pipeline register slice.
interface airi5c_pipe_regs_if #(
  parameter int DATA_W = 32,
  parameter int FLAG_W = 2,
  parameter int CNT_W  = 8
) ();
  logic              stall;
  logic              flush;
  logic              valid_in;
  logic              kill_in;
  logic [DATA_W-1:0] data_in;
  logic [FLAG_W-1:0] flags_in;
  logic              valid_out;
  logic              killed_out;
  logic              bubble_out;
  logic [DATA_W-1:0] data_out;
  logic [FLAG_W-1:0] flags_out;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output stall, flush, valid_in, kill_in, data_in, flags_in,
    input  valid_out, killed_out, bubble_out, data_out, flags_out, stall_cnt
  );

  modport slave (
    input  stall, flush, valid_in, kill_in, data_in, flags_in,
    output valid_out, killed_out, bubble_out, data_out, flags_out, stall_cnt
  );
endinterface

// File: rtl/airi5c_pipe_regs_stage.sv
// One pipeline stage: holds valid/killed/data/flags and applies the
// flush > stall > advance update, with payload kept for dead instructions.
module airi5c_pipe_stage
  import airi5c_pipe_regs_pkg::*;
#(
  parameter int                DATA_W   = PIPE_DATA_W_DEF,
  parameter int                FLAG_W   = PIPE_FLAG_W_DEF,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  pipe_op_e          op,
  input  logic              up_valid,
  input  logic              up_kill,
  input  logic [DATA_W-1:0] up_data,
  input  logic [FLAG_W-1:0] up_flags,
  output logic              valid,
  output logic              killed,
  output logic [DATA_W-1:0] data,
  output logic [FLAG_W-1:0] flags
);

  logic up_live;
  assign up_live = up_valid & ~up_kill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid  <= 1'b0;
      killed <= 1'b0;
      data   <= RST_DATA;
      flags  <= '0;
    end else begin
      case (op)
        PIPE_FLUSH: begin
          valid  <= 1'b0;
          killed <= 1'b0;
        end
        PIPE_STALL: ;
        default: begin
          valid  <= up_live;
          killed <= up_valid & up_kill;
          flags  <= up_flags;
          if (up_live) data <= up_data;
        end
      endcase
    end
  end

endmodule

// File: rtl/airi5c_pipe_regs.sv
// DEPTH-stage pipeline register chain with kill tracking, flush/stall
// control and a saturating consecutive-stall counter.
module airi5c_pipe_regs
  import airi5c_pipe_regs_pkg::*;
#(
  parameter int                DATA_W   = PIPE_DATA_W_DEF,
  parameter int                FLAG_W   = PIPE_FLAG_W_DEF,
  parameter int                DEPTH    = PIPE_DEPTH_DEF,
  parameter logic [DATA_W-1:0] RST_DATA = '0,
  parameter int                CNT_W    = PIPE_CNT_W_DEF
) (
  input logic              clk,
  input logic              reset,
  airi5c_pipe_regs_if.slave bus
);

  if (DEPTH < PIPE_DEPTH_MIN || DEPTH > PIPE_DEPTH_MAX) begin : g_bad_depth
    $error("airi5c_pipe_regs: DEPTH=%0d outside %0d..%0d",
           DEPTH, PIPE_DEPTH_MIN, PIPE_DEPTH_MAX);
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pipe_op_e          op;
  logic              st_valid  [DEPTH];
  logic              st_killed [DEPTH];
  logic [DATA_W-1:0] st_data   [DEPTH];
  logic [FLAG_W-1:0] st_flags  [DEPTH];
  logic [CNT_W-1:0]  stall_cnt_q;

  assign op = pipe_op(bus.stall, bus.flush);

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic              up_valid;
    logic              up_kill;
    logic [DATA_W-1:0] up_data;
    logic [FLAG_W-1:0] up_flags;

    if (g == 0) begin : g_head
      assign up_valid = bus.valid_in;
      assign up_kill  = bus.kill_in;
      assign up_data  = bus.data_in;
      assign up_flags = bus.flags_in;
    end else begin : g_tail
      // A killed instruction still occupies its slot, so it travels on as killed.
      assign up_valid = st_valid[g-1] | st_killed[g-1];
      assign up_kill  = st_killed[g-1];
      assign up_data  = st_data[g-1];
      assign up_flags = st_flags[g-1];
    end

    airi5c_pipe_stage #(
      .DATA_W   (DATA_W),
      .FLAG_W   (FLAG_W),
      .RST_DATA (RST_DATA)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .op       (op),
      .up_valid (up_valid),
      .up_kill  (up_kill),
      .up_data  (up_data),
      .up_flags (up_flags),
      .valid    (st_valid[g]),
      .killed   (st_killed[g]),
      .data     (st_data[g]),
      .flags    (st_flags[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (op != PIPE_STALL) begin
      stall_cnt_q <= '0;
    end else if (stall_cnt_q != CNT_MAX) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.valid_out  = st_valid[DEPTH-1];
  assign bus.killed_out = st_killed[DEPTH-1];
  assign bus.bubble_out = ~st_valid[DEPTH-1];
  assign bus.data_out   = st_data[DEPTH-1];
  assign bus.flags_out  = st_flags[DEPTH-1];
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_airi5c_pipe_regs.sv
// Directed bench for airi5c_pipe_regs across four depth/counter configurations.
module tb_airi5c_pipe_regs;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] RST2 = 32'hDEAD_BEEF;

  airi5c_pipe_regs_if #(.DATA_W(32), .FLAG_W(2), .CNT_W(8)) b1 ();
  airi5c_pipe_regs_if #(.DATA_W(32), .FLAG_W(2), .CNT_W(8)) b2 ();
  airi5c_pipe_regs_if #(.DATA_W(32), .FLAG_W(2), .CNT_W(8)) b3 ();
  airi5c_pipe_regs_if #(.DATA_W(32), .FLAG_W(2), .CNT_W(3)) bc ();

  airi5c_pipe_regs #(.DATA_W(32), .FLAG_W(2), .DEPTH(1), .CNT_W(8))
    u1 (.clk(clk), .reset(reset), .bus(b1));
  airi5c_pipe_regs #(.DATA_W(32), .FLAG_W(2), .DEPTH(2), .RST_DATA(RST2), .CNT_W(8))
    u2 (.clk(clk), .reset(reset), .bus(b2));
  airi5c_pipe_regs #(.DATA_W(32), .FLAG_W(2), .DEPTH(3), .CNT_W(8))
    u3 (.clk(clk), .reset(reset), .bus(b3));
  airi5c_pipe_regs #(.DATA_W(32), .FLAG_W(2), .DEPTH(1), .CNT_W(3))
    uc (.clk(clk), .reset(reset), .bus(bc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #3;
    total++; if (b2.valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", b2.valid_out); end
    total++; if (b2.killed_out !== 1'b0) begin bad++; $display("FAIL rst_killed: got %0b want 0", b2.killed_out); end
    total++; if (b2.bubble_out !== 1'b1) begin bad++; $display("FAIL rst_bubble: got %0b want 1", b2.bubble_out); end
    total++; if (b2.data_out !== RST2) begin bad++; $display("FAIL rst_data: got %h want %h", b2.data_out, RST2); end
    total++; if (b2.flags_out !== 2'b00) begin bad++; $display("FAIL rst_flags: got %b want 00", b2.flags_out); end
    total++; if (b3.stall_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", b3.stall_cnt); end
    total++; if (b1.data_out !== 32'd0) begin bad++; $display("FAIL rst_data1: got %h want 0", b1.data_out); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_latency();
    @(negedge clk);
    b2.valid_in = 1'b1; b2.data_in = 32'hA5A5_0001; b2.flags_in = 2'b01;
    @(negedge clk);
    b2.valid_in = 1'b0; b2.data_in = 32'hFFFF_FFFF; b2.flags_in = 2'b00;
    total++; if (b2.valid_out !== 1'b0) begin bad++; $display("FAIL lat_early: got %0b want 0", b2.valid_out); end
    @(negedge clk);
    total++; if (b2.valid_out !== 1'b1) begin bad++; $display("FAIL lat_valid: got %0b want 1", b2.valid_out); end
    total++; if (b2.data_out !== 32'hA5A5_0001) begin bad++; $display("FAIL lat_data: got %h want a5a50001", b2.data_out); end
    total++; if (b2.flags_out !== 2'b01) begin bad++; $display("FAIL lat_flags: got %b want 01", b2.flags_out); end
    total++; if (b2.bubble_out !== 1'b0) begin bad++; $display("FAIL lat_bubble: got %0b want 0", b2.bubble_out); end
    @(negedge clk);
    total++; if (b2.valid_out !== 1'b0) begin bad++; $display("FAIL lat_after: got %0b want 0", b2.valid_out); end
    total++; if (b2.data_out !== 32'hA5A5_0001) begin bad++; $display("FAIL lat_hold: got %h want a5a50001", b2.data_out); end
    total++; if (b2.flags_out !== 2'b00) begin bad++; $display("FAIL lat_flags2: got %b want 00", b2.flags_out); end
  endtask

  task automatic test_kill();
    @(negedge clk);
    b1.valid_in = 1'b1; b1.kill_in = 1'b0; b1.data_in = 32'h5555; b1.flags_in = 2'b01;
    @(negedge clk);
    total++; if (b1.data_out !== 32'h5555) begin bad++; $display("FAIL kill_pre: got %h want 5555", b1.data_out); end
    b1.valid_in = 1'b1; b1.kill_in = 1'b1; b1.data_in = 32'h1234; b1.flags_in = 2'b10;
    @(negedge clk);
    total++; if (b1.killed_out !== 1'b1) begin bad++; $display("FAIL kill_killed: got %0b want 1", b1.killed_out); end
    total++; if (b1.valid_out !== 1'b0) begin bad++; $display("FAIL kill_valid: got %0b want 0", b1.valid_out); end
    total++; if (b1.flags_out !== 2'b10) begin bad++; $display("FAIL kill_flags: got %b want 10", b1.flags_out); end
    total++; if (b1.data_out !== 32'h5555) begin bad++; $display("FAIL kill_data: got %h want 5555", b1.data_out); end
    total++; if (b1.bubble_out !== 1'b1) begin bad++; $display("FAIL kill_bubble: got %0b want 1", b1.bubble_out); end
    b1.valid_in = 1'b0; b1.kill_in = 1'b1; b1.data_in = 32'h9999; b1.flags_in = 2'b01;
    @(negedge clk);
    total++; if (b1.killed_out !== 1'b0) begin bad++; $display("FAIL kill_novalid: got %0b want 0", b1.killed_out); end
    total++; if (b1.flags_out !== 2'b01) begin bad++; $display("FAIL kill_nvflags: got %b want 01", b1.flags_out); end
    total++; if (b1.data_out !== 32'h5555) begin bad++; $display("FAIL kill_nvdata: got %h want 5555", b1.data_out); end
    b1.kill_in = 1'b0; b1.flags_in = 2'b00;
    // killed instruction carried through two stages
    b2.valid_in = 1'b1; b2.kill_in = 1'b1; b2.data_in = 32'h4444;
    @(negedge clk);
    b2.valid_in = 1'b0; b2.kill_in = 1'b0;
    @(negedge clk);
    total++; if (b2.killed_out !== 1'b1) begin bad++; $display("FAIL kill_deep: got %0b want 1", b2.killed_out); end
    total++; if (b2.data_out !== 32'hA5A5_0001) begin bad++; $display("FAIL kill_deepdata: got %h want a5a50001", b2.data_out); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    b3.valid_in = 1'b1; b3.data_in = 32'h10;
    @(negedge clk); b3.data_in = 32'h11;
    @(negedge clk); b3.data_in = 32'h12;
    @(negedge clk);
    total++; if (b3.data_out !== 32'h10) begin bad++; $display("FAIL stall_fill: got %h want 10", b3.data_out); end
    b3.stall = 1'b1; b3.data_in = 32'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (b3.data_out !== 32'h10 || b3.valid_out !== 1'b1) begin bad++; $display("FAIL stall_frozen[%0d]: got %h/%0b want 10/1", i, b3.data_out, b3.valid_out); end
      total++; if (b3.stall_cnt !== 8'(i + 1)) begin bad++; $display("FAIL stall_cnt[%0d]: got %0d want %0d", i, b3.stall_cnt, i + 1); end
    end
    b3.stall = 1'b0; b3.data_in = 32'h13;
    @(negedge clk);
    total++; if (b3.stall_cnt !== 8'd0) begin bad++; $display("FAIL stall_clr: got %0d want 0", b3.stall_cnt); end
    total++; if (b3.data_out !== 32'h11) begin bad++; $display("FAIL stall_r1: got %h want 11", b3.data_out); end
    b3.valid_in = 1'b0;
    @(negedge clk);
    total++; if (b3.data_out !== 32'h12) begin bad++; $display("FAIL stall_r2: got %h want 12", b3.data_out); end
    @(negedge clk);
    total++; if (b3.data_out !== 32'h13 || b3.valid_out !== 1'b1) begin bad++; $display("FAIL stall_r3: got %h/%0b want 13/1", b3.data_out, b3.valid_out); end
    @(negedge clk);
    total++; if (b3.valid_out !== 1'b0) begin bad++; $display("FAIL stall_drain: got %0b want 0", b3.valid_out); end
  endtask

  task automatic test_stall_flush();
    @(negedge clk);
    b3.valid_in = 1'b1; b3.data_in = 32'h20;
    @(negedge clk); b3.data_in = 32'h21;
    @(negedge clk); b3.data_in = 32'h22;
    @(negedge clk);
    b3.valid_in = 1'b0; b3.stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (b3.stall_cnt !== 8'd2) begin bad++; $display("FAIL sf_cnt_pre: got %0d want 2", b3.stall_cnt); end
    b3.flush = 1'b1;
    @(negedge clk);
    total++; if (b3.valid_out !== 1'b0) begin bad++; $display("FAIL sf_valid: got %0b want 0", b3.valid_out); end
    total++; if (b3.killed_out !== 1'b0) begin bad++; $display("FAIL sf_killed: got %0b want 0", b3.killed_out); end
    total++; if (b3.bubble_out !== 1'b1) begin bad++; $display("FAIL sf_bubble: got %0b want 1", b3.bubble_out); end
    total++; if (b3.stall_cnt !== 8'd0) begin bad++; $display("FAIL sf_cnt: got %0d want 0", b3.stall_cnt); end
    total++; if (b3.data_out !== 32'h20) begin bad++; $display("FAIL sf_data: got %h want 20", b3.data_out); end
    b3.flush = 1'b0; b3.stall = 1'b0;
    @(negedge clk);
    total++; if (b3.valid_out !== 1'b0) begin bad++; $display("FAIL sf_empty: got %0b want 0", b3.valid_out); end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    bc.stall = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      total++; if (bc.stall_cnt !== 3'((i > 7) ? 7 : i)) begin bad++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, bc.stall_cnt, (i > 7) ? 7 : i); end
    end
    bc.stall = 1'b0;
    @(negedge clk);
    total++; if (bc.stall_cnt !== 3'd0) begin bad++; $display("FAIL sat_clr: got %0d want 0", bc.stall_cnt); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    b2.valid_in = 1'b1; b2.data_in = 32'h77; b2.flags_in = 2'b11;
    @(negedge clk);
    b2.valid_in = 1'b0; b2.flags_in = 2'b00; b3.stall = 1'b1;
    @(negedge clk);
    total++; if (b2.valid_out !== 1'b1 || b2.data_out !== 32'h77) begin bad++; $display("FAIL ar_pre: got %0b/%h want 1/77", b2.valid_out, b2.data_out); end
    total++; if (b3.stall_cnt !== 8'd1) begin bad++; $display("FAIL ar_cntpre: got %0d want 1", b3.stall_cnt); end
    #2 reset = 1'b1;
    #1;
    total++; if (b2.valid_out !== 1'b0) begin bad++; $display("FAIL ar_valid: got %0b want 0", b2.valid_out); end
    total++; if (b2.data_out !== RST2) begin bad++; $display("FAIL ar_data: got %h want %h", b2.data_out, RST2); end
    total++; if (b2.flags_out !== 2'b00) begin bad++; $display("FAIL ar_flags: got %b want 00", b2.flags_out); end
    total++; if (b3.stall_cnt !== 8'd0) begin bad++; $display("FAIL ar_cnt: got %0d want 0", b3.stall_cnt); end
    #1 reset = 1'b0;
    @(negedge clk);
    total++; if (b3.stall_cnt !== 8'd1) begin bad++; $display("FAIL ar_post_cnt: got %0d want 1", b3.stall_cnt); end
    total++; if (b2.valid_out !== 1'b0 || b2.data_out !== RST2) begin bad++; $display("FAIL ar_post: got %0b/%h want 0/%h", b2.valid_out, b2.data_out, RST2); end
    b3.stall = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    b1.stall = 0; b1.flush = 0; b1.valid_in = 0; b1.kill_in = 0; b1.data_in = '0; b1.flags_in = '0;
    b2.stall = 0; b2.flush = 0; b2.valid_in = 0; b2.kill_in = 0; b2.data_in = '0; b2.flags_in = '0;
    b3.stall = 0; b3.flush = 0; b3.valid_in = 0; b3.kill_in = 0; b3.data_in = '0; b3.flags_in = '0;
    bc.stall = 0; bc.flush = 0; bc.valid_in = 0; bc.kill_in = 0; bc.data_in = '0; bc.flags_in = '0;
    test_reset();
    test_latency();
    test_kill();
    test_stall();
    test_stall_flush();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
